// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/gnt/rvalid port, execute redirect,
// and the valid/ready word stream into decode. master = fetch unit, slave = environment.
interface fetch_unit_if;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instr;
    logic [31:0] instrPc;
    logic [31:0] instrPcPlus4;
    logic [6:0]  opcode;

    modport master (
        output imemReq, imemAddr, instrValid, instr, instrPc, instrPcPlus4, opcode,
        input  imemGnt, imemRvalid, imemRdata, redirect, redirectPc, instrReady
    );

    modport slave (
        input  imemReq, imemAddr, instrValid, instr, instrPc, instrPcPlus4, opcode,
        output imemGnt, imemRvalid, imemRdata, redirect, redirectPc, instrReady
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, credit-limited imem requests, in-order response
// buffering in a small FIFO, and squashing of wrong-path words after a redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    typedef enum logic [0:0] {StRun, StSquash} mode_e;

    logic [31:0] pc_q;
    logic [31:0] infl_pc_q [DEPTH];
    ptr_t        infl_wr_q, infl_rd_q;
    logic [31:0] fifo_word_q [DEPTH];
    logic [31:0] fifo_pc_q   [DEPTH];
    ptr_t        fifo_wr_q, fifo_rd_q;
    cnt_t        count_q;
    cnt_t        outstanding_q;
    cnt_t        discard_q;
    mode_e       mode_q;

    logic        valid;
    logic        pop;
    logic        credit;
    logic        req;
    logic        accept;
    logic        rsp;
    logic        keep;
    logic [CW:0] used;
    cnt_t        outstanding_d;
    logic        unused_redirect_lsb;

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // Low address bits of a redirect target are forced to word alignment.
    assign unused_redirect_lsb = ^bus.redirectPc[1:0];

    assign valid  = (count_q != '0);
    assign pop    = valid & bus.instrReady;
    // Words in the FIFO plus words still in flight may never exceed the buffer depth.
    assign used   = (CW + 1)'(count_q) + (CW + 1)'(outstanding_q) - (CW + 1)'(pop);
    assign credit = (used < (CW + 1)'(DEPTH));
    assign req    = rst_n & ~bus.redirect & credit;
    assign accept = req & bus.imemGnt;
    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp    = bus.imemRvalid & (outstanding_q != '0);
    assign keep   = rsp & (mode_q == StRun);

    assign outstanding_d = outstanding_q + cnt_t'(accept) - cnt_t'(rsp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            infl_wr_q     <= '0;
            infl_rd_q     <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            mode_q        <= StRun;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                infl_pc_q[i]   <= '0;
                fifo_word_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else begin
            if (accept) begin
                infl_pc_q[infl_wr_q] <= pc_q;
                infl_wr_q            <= ptr_inc(infl_wr_q);
                pc_q                 <= pc_q + 32'd4;
            end
            if (rsp) begin
                infl_rd_q <= ptr_inc(infl_rd_q);
            end
            outstanding_q <= outstanding_d;

            if (bus.redirect) begin
                // Everything still in flight after this cycle belongs to the old path.
                pc_q      <= {bus.redirectPc[31:2], 2'b00};
                fifo_wr_q <= '0;
                fifo_rd_q <= '0;
                count_q   <= '0;
                discard_q <= outstanding_d;
                mode_q    <= (outstanding_d != '0) ? StSquash : StRun;
            end else begin
                if (keep) begin
                    fifo_word_q[fifo_wr_q] <= bus.imemRdata;
                    fifo_pc_q[fifo_wr_q]   <= infl_pc_q[infl_rd_q];
                    fifo_wr_q              <= ptr_inc(fifo_wr_q);
                end
                if (pop) begin
                    fifo_rd_q <= ptr_inc(fifo_rd_q);
                end
                count_q <= count_q + cnt_t'(keep) - cnt_t'(pop);

                unique case (mode_q)
                    StRun: begin
                        discard_q <= '0;
                    end
                    StSquash: begin
                        if (rsp) begin
                            discard_q <= discard_q - cnt_t'(1);
                            if (discard_q == cnt_t'(1)) begin
                                mode_q <= StRun;
                            end
                        end
                    end
                    default: begin
                        mode_q <= StRun;
                    end
                endcase
            end
        end
    end

    assign bus.imemReq      = req;
    assign bus.imemAddr     = pc_q;
    assign bus.instrValid   = valid;
    assign bus.instr        = valid ? fifo_word_q[fifo_rd_q] : 32'h0;
    assign bus.instrPc      = valid ? fifo_pc_q[fifo_rd_q] : 32'h0;
    assign bus.instrPcPlus4 = valid ? fifo_pc_q[fifo_rd_q] + 32'd4 : 32'h0;
    assign bus.opcode       = bus.instr[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural memory with configurable latency, and a scoreboard of
// granted good-path addresses compared against every word handed to decode.
module tb_fetch_unit;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    fetch_unit_if bus();

    fetch_unit #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    req_t        pend[$];
    logic [31:0] expq[$];
    int          occ;
    int          cyc;
    int          lat;
    bit          ready_en;
    bit          gnt_en;
    logic [31:0] next_pc;
    int          n_checks;
    int          n_errors;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at a falling edge: drive inputs, check outputs, advance the model, wait one cycle.
    task automatic cycle(input bit redir, input logic [31:0] tgt);
        bit          rv;
        bit          pop;
        bit          req_exp;
        req_t        head;
        logic [31:0] e;
        logic [31:0] w;

        rv = (pend.size() > 0) && (pend[0].due <= cyc);
        bus.instrReady = ready_en;
        bus.imemGnt    = gnt_en;
        bus.redirect   = redir;
        bus.redirectPc = tgt;
        bus.imemRvalid = rv;
        bus.imemRdata  = rv ? mem_word(pend[0].addr) : 32'hDEAD_BEEF;
        #1;

        check("instr_valid", 32'(bus.instrValid), 32'(occ > 0));
        if (occ > 0) begin
            e = (expq.size() > 0) ? expq[0] : 32'hFFFF_FFFF;
            w = mem_word(e);
            check("instr_pc", bus.instrPc, e);
            check("instr", bus.instr, w);
            check("instr_pc_plus4", bus.instrPcPlus4, e + 32'd4);
            check("opcode", 32'(bus.opcode), 32'(w[6:0]));
        end else begin
            check("instr_idle_zero", bus.instr, 32'h0);
            check("opcode_idle_zero", 32'(bus.opcode), 32'h0);
        end

        pop     = (occ > 0) && ready_en;
        req_exp = !redir && ((occ + pend.size() - int'(pop)) < int'(DEPTH));
        check("imem_req", 32'(bus.imemReq), 32'(req_exp));
        if (bus.imemReq) begin
            check("imem_addr", bus.imemAddr, next_pc);
        end

        if (pop && !redir && expq.size() > 0) begin
            void'(expq.pop_front());
            occ--;
        end
        if (rv) begin
            head = pend.pop_front();
            if (!head.stale) occ++;
        end
        if (bus.imemReq && gnt_en) begin
            pend.push_back('{addr: next_pc, due: cyc + lat, stale: 1'b0});
            expq.push_back(next_pc);
            next_pc = next_pc + 32'd4;
            check("credit_bound", 32'(occ + pend.size() <= int'(DEPTH)), 32'd1);
        end
        if (redir) begin
            occ = 0;
            expq.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            next_pc = {tgt[31:2], 2'b00};
        end

        @(negedge clk);
        cyc++;
    endtask

    // Asserts reset (memory is reset alongside), checks the cleared outputs, releases on a
    // falling edge.
    task automatic do_reset();
        #2;
        rst_n          = 1'b0;
        bus.imemGnt    = 1'b0;
        bus.imemRvalid = 1'b0;
        bus.redirect   = 1'b0;
        pend.delete();
        expq.delete();
        occ     = 0;
        next_pc = RESET_PC;
        #1;
        check("rst_imem_req", 32'(bus.imemReq), 32'h0);
        check("rst_instr_valid", 32'(bus.instrValid), 32'h0);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_opcode", 32'(bus.opcode), 32'h0);
        check("rst_instr_pc", bus.instrPc, 32'h0);
        check("rst_instr_pc_plus4", bus.instrPcPlus4, 32'h0);
        @(negedge clk);
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        cyc            = 0;
        lat            = 1;
        ready_en       = 1'b1;
        gnt_en         = 1'b1;
        occ            = 0;
        next_pc        = RESET_PC;
        bus.imemGnt    = 1'b0;
        bus.imemRvalid = 1'b0;
        bus.imemRdata  = 32'h0;
        bus.redirect   = 1'b0;
        bus.redirectPc = 32'h0;
        bus.instrReady = 1'b0;

        do_reset();

        // Streaming with a stall of the grant at address 0x8.
        cycle(1'b0, 32'h0);
        cycle(1'b0, 32'h0);
        gnt_en = 1'b0;
        repeat (3) cycle(1'b0, 32'h0);
        gnt_en = 1'b1;
        repeat (8) cycle(1'b0, 32'h0);

        // Decode back-pressure.
        ready_en = 1'b0;
        repeat (5) cycle(1'b0, 32'h0);
        ready_en = 1'b1;
        repeat (8) cycle(1'b0, 32'h0);

        // Redirects with slow memory: one while words are in flight, one during squash.
        lat = 3;
        for (int i = 0; i < 10 && pend.size() < DEPTH; i++) cycle(1'b0, 32'h0);
        check("inflight_before_redirect", 32'(pend.size()), 32'(DEPTH));
        cycle(1'b1, 32'h0000_0103);
        cycle(1'b0, 32'h0);
        cycle(1'b1, 32'h0000_0200);
        repeat (15) cycle(1'b0, 32'h0);

        // Random mix of latency, grant gaps, back-pressure and redirects.
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 7) == 0) lat = int'($urandom_range(1, 3));
            ready_en = ($urandom_range(0, 3) != 0);
            gnt_en   = ($urandom_range(0, 3) != 0);
            cycle($urandom_range(0, 19) == 0, $urandom);
        end

        // Fill the FIFO, then reset mid-operation.
        lat      = 1;
        gnt_en   = 1'b1;
        ready_en = 1'b0;
        for (int i = 0; i < 20 && occ < int'(DEPTH); i++) cycle(1'b0, 32'h0);
        check("fifo_full_before_reset", 32'(occ), 32'(DEPTH));
        do_reset();
        ready_en = 1'b1;
        repeat (8) cycle(1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
